// File: rtl/acos_q16.sv
// acos_q16: Q16.16 arccosine. Squares c, takes s = sqrt(1 - c^2) bit-serially,
// then runs CORDIC vectoring on (c, s) and keeps only the angle accumulator.
//
// state  | meaning
// IDLE   | waiting for start, last result held on xita
// SQ     | radicand {1 - c^2, 16'h0} formed from the squared operand
// SQRT   | restoring square root, two radicand bits per cycle
// PRE    | load CORDIC vector, pre-rotate by pi/2 when c < 0
// CORDIC | vectoring iterations, angle accumulated in z
// DONE   | clamp angle, post result and warn
`timescale 1ns/1ps

module acos_q16 #(
  parameter int ITERS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cos_in,
  output logic        busy,
  output logic        valid,
  output logic [31:0] xita,
  output logic        warn
);

  localparam logic [31:0] ONE     = 32'h0001_0000;
  localparam logic [31:0] M_ONE   = 32'hFFFF_0000;
  localparam logic [31:0] HALF_PI = 32'h0001_921F;
  localparam logic [31:0] PI      = 32'h0003_243F;

  typedef enum logic [2:0] {IDLE, SQ, SQRT, PRE, CORDIC, DONE} state_t;

  state_t             state;
  logic signed [31:0] c;
  logic               warn_r;
  logic [47:0]        rad;
  logic [25:0]        rem;
  logic [23:0]        root;
  logic signed [33:0] x;
  logic signed [33:0] y;
  logic [31:0]        z;
  logic [4:0]         cnt;

  logic [31:0] c_clamp;
  logic        clamp_hit;

  always_comb begin
    c_clamp   = cos_in;
    clamp_hit = 1'b0;
    if ($signed(cos_in) > $signed(ONE)) begin
      c_clamp   = ONE;
      clamp_hit = 1'b1;
    end else if ($signed(cos_in) < $signed(M_ONE)) begin
      c_clamp   = M_ONE;
      clamp_hit = 1'b1;
    end
  end

  // {1 - c2, 16'h0}: the low product bits are dropped, which truncates c2
  logic signed [47:0] c48;
  logic signed [47:0] p48;
  logic [47:0]        rad_init;

  assign c48      = {{16{c[31]}}, c};
  assign p48      = c48 * c48;
  assign rad_init = {ONE, 16'h0000} - (p48 & 48'hFFFF_FFFF_0000);

  logic [27:0] rem_sh;
  logic [27:0] trial;
  logic        fits;

  assign rem_sh = {rem, rad[47:46]};
  assign trial  = rem_sh - {2'b00, root, 2'b01};
  assign fits   = ~trial[27] & ~trial[26];

  logic [4:0]         idx;
  logic signed [33:0] x_sh;
  logic signed [33:0] y_sh;
  logic signed [33:0] c34;
  logic signed [33:0] s34;
  logic [31:0]        atan_v;
  logic [31:0]        z_sat;

  assign idx  = 5'(ITERS - 1) - cnt;
  assign x_sh = x >>> idx;
  assign y_sh = y >>> idx;
  assign c34  = {{2{c[31]}}, c};
  assign s34  = {10'b0, root};

  always_comb begin
    atan_v = 32'h0;
    case (idx)
      5'd0:  atan_v = 32'h0000_C910;
      5'd1:  atan_v = 32'h0000_76B2;
      5'd2:  atan_v = 32'h0000_3EB7;
      5'd3:  atan_v = 32'h0000_1FD6;
      5'd4:  atan_v = 32'h0000_0FFB;
      5'd5:  atan_v = 32'h0000_07FF;
      5'd6:  atan_v = 32'h0000_0400;
      5'd7:  atan_v = 32'h0000_0200;
      5'd8:  atan_v = 32'h0000_0100;
      5'd9:  atan_v = 32'h0000_0080;
      5'd10: atan_v = 32'h0000_0040;
      5'd11: atan_v = 32'h0000_0020;
      5'd12: atan_v = 32'h0000_0010;
      5'd13: atan_v = 32'h0000_0008;
      5'd14: atan_v = 32'h0000_0004;
      5'd15: atan_v = 32'h0000_0002;
      5'd16: atan_v = 32'h0000_0001;
      default: atan_v = 32'h0;
    endcase
  end

  always_comb begin
    z_sat = z;
    if (z[31])
      z_sat = 32'h0;
    else if (z > PI)
      z_sat = PI;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      c      <= '0;
      warn_r <= 1'b0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      warn   <= 1'b0;
      xita   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c      <= c_clamp;
            warn_r <= clamp_hit;
            rem    <= '0;
            root   <= '0;
            busy   <= 1'b1;
            valid  <= 1'b0;
            state  <= SQ;
          end
        end
        SQ: begin
          rad   <= rad_init;
          cnt   <= 5'd23;
          state <= SQRT;
        end
        SQRT: begin
          rad <= {rad[45:0], 2'b00};
          if (fits) begin
            rem  <= trial[25:0];
            root <= {root[22:0], 1'b1};
          end else begin
            rem  <= rem_sh[25:0];
            root <= {root[22:0], 1'b0};
          end
          if (cnt == 5'd0)
            state <= PRE;
          else
            cnt <= cnt - 5'd1;
        end
        PRE: begin
          // negative c: rotate (c, s) by -pi/2 so vectoring stays in the right half plane
          if (!c[31]) begin
            x <= c34;
            y <= s34;
            z <= 32'h0;
          end else begin
            x <= s34;
            y <= -c34;
            z <= HALF_PI;
          end
          cnt   <= 5'(ITERS - 1);
          state <= CORDIC;
        end
        CORDIC: begin
          if (!y[33]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_v;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_v;
          end
          if (cnt == 5'd0)
            state <= DONE;
          else
            cnt <= cnt - 5'd1;
        end
        DONE: begin
          xita  <= z_sat;
          warn  <= warn_r;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acos_q16.sv
// tb_acos_q16: directed and randomized checks of acos_q16 against a real-valued acos model.
`timescale 1ns/1ps

module tb_acos_q16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cos_in;
  logic        busy;
  logic        valid;
  logic [31:0] xita;
  logic        warn;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  acos_q16 #(.ITERS(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cos_in (cos_in),
    .busy   (busy),
    .valid  (valid),
    .xita   (xita),
    .warn   (warn)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input int tol);
    int diff;
    diff = int'(obs) - int'(exp);
    n_checks++;
    if (diff <= tol && diff >= -tol)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h, want 0x%08h (+/-%0d)", tag, obs, exp, tol);
  endtask

  function automatic logic [31:0] ref_xita(input logic [31:0] ci);
    int  v;
    real a;
    int  q;
    v = $signed(ci);
    if (v > 65536)  v = 65536;
    if (v < -65536) v = -65536;
    a = $acos(real'(v) / 65536.0) * 65536.0;
    q = $rtoi(a + 0.5);
    if (q > 32'h0003_243F) q = 32'h0003_243F;
    return 32'(q);
  endfunction

  function automatic logic ref_warn(input logic [31:0] ci);
    int v;
    v = $signed(ci);
    return (v > 65536) || (v < -65536);
  endfunction

  // One operation: start at a posedge (or in the cycle valid rose, for b2b),
  // count falling edges until valid; optionally disturb inputs while busy.
  task automatic run_op(input logic [31:0] val, input bit b2b, input bit disturb,
                        output logic [31:0] res, output logic w);
    logic [31:0] old_x;
    int lat;
    int gap;
    if (!b2b) @(posedge clk);
    old_x  = xita;
    start  = 1'b1;
    cos_in = val;
    @(posedge clk);
    start = 1'b0;
    check_val("busy_on_accept", busy, 1, 0);
    if (b2b) begin
      check_val("b2b_valid_drop", valid, 0, 0);
      check_val("b2b_xita_hold", xita, old_x, 0);
    end
    lat = 0;
    gap = 0;
    while (!valid && lat < 100) begin
      if (disturb && lat == 5) begin
        start  = 1'b1;
        cos_in = 32'hFFFF_0000;
      end
      if (disturb && lat == 7) start = 1'b0;
      if (!busy) gap++;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    check_val("latency", lat, 43, 0);
    check_val("busy_gap", gap, 0, 0);
    check_val("busy_off_at_valid", busy, 0, 0);
    res = xita;
    w   = warn;
  endtask

  logic [31:0] d_in  [7] = '{32'h0001_0000, 32'h0000_0000, 32'hFFFF_0000,
                             32'h0000_8000, 32'hFFFF_8000, 32'h0002_0000, 32'h8000_0000};
  logic [31:0] d_exp [7] = '{32'h0000_0000, 32'h0001_921F, 32'h0003_243F,
                             32'h0001_0C15, 32'h0002_182A, 32'h0000_0000, 32'h0003_243F};
  logic        d_warn[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    logic        w;
    logic [31:0] v;

    rst_n  = 1'b0;
    start  = 1'b0;
    cos_in = 32'h0;
    repeat (3) @(posedge clk);
    check_val("rst_busy", busy, 0, 0);
    check_val("rst_valid", valid, 0, 0);
    check_val("rst_warn", warn, 0, 0);
    check_val("rst_xita", xita, 0, 0);
    rst_n = 1'b1;

    // exact points, +/-0.5 and clamped inputs
    for (int i = 0; i < 7; i++) begin
      run_op(d_in[i], 1'b0, 1'b0, res, w);
      check_val($sformatf("xita_%08h", d_in[i]), res, d_exp[i], 8);
      check_val($sformatf("warn_%08h", d_in[i]), w, d_warn[i], 0);
    end

    // inputs toggled and start repeated while busy: first operand must win
    run_op(32'h0000_8000, 1'b0, 1'b1, res, w);
    check_val("disturb_xita", res, 32'h0001_0C15, 8);
    check_val("disturb_warn", w, 0, 0);

    // back-to-back start in the cycle after valid rises
    run_op(32'hFFFF_8000, 1'b1, 1'b0, res, w);
    check_val("b2b_xita", res, 32'h0002_182A, 8);

    // leave a clamped result posted so reset clearing is visible
    run_op(32'h8000_0000, 1'b0, 1'b0, res, w);
    check_val("pre_rst_warn", w, 1, 0);

    // reset ten cycles into an operation
    @(posedge clk);
    start  = 1'b1;
    cos_in = 32'h0000_4000;
    @(posedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0, 0);
    check_val("midrst_valid", valid, 0, 0);
    check_val("midrst_warn", warn, 0, 0);
    check_val("midrst_xita", xita, 0, 0);
    @(posedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_8000, 1'b0, 1'b0, res, w);
    check_val("post_rst_xita", res, 32'h0001_0C15, 8);
    check_val("post_rst_warn", w, 0, 0);

    // ascending random sweep, one sample per 512-LSB stratum
    prev = 32'hFFFF_FFFF;
    for (int k = 0; k < 256; k++) begin
      v = 32'(-65536 + k * 512 + int'($urandom_range(0, 255)));
      run_op(v, 1'b0, 1'b0, res, w);
      check_val($sformatf("sweep_%08h", v), res, ref_xita(v), 8);
      check_val($sformatf("sweep_warn_%08h", v), w, ref_warn(v), 0);
      if (k > 0)
        check_val($sformatf("mono_%08h", v), {31'b0, res <= prev}, 1, 0);
      prev = res;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
